// File: rtl/sd_cmd_master_q.sv
// sd_cmd_master_q: queued SD command master with automatic retry,
// watchdog timeout and debounced card-detect queue flush.
module sd_cmd_master_q #(
    parameter int QUEUE_DEPTH = 4,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_W   = 16,
    parameter int DEBOUNCE_W  = 4
) (
    input  logic                         CLK_PAD_IO,
    input  logic                         RST_PAD_NI,
    input  logic                         cmd_push_i,
    input  logic [13:0]                  cmd_set_i,
    input  logic [31:0]                  arg_i,
    input  logic                         data_read_i,
    input  logic                         data_write_i,
    output logic                         cmd_full_o,
    output logic [$clog2(QUEUE_DEPTH):0] cmd_level_o,
    input  logic [TIMEOUT_W-1:0]         TIMEOUT_REG,
    output logic [15:0]                  STATUS_REG,
    output logic [31:0]                  RESP_1_REG,
    output logic [4:0]                   ERR_INT_REG,
    output logic [15:0]                  NORMAL_INT_REG,
    input  logic                         ERR_INT_RST,
    input  logic                         NORMAL_INT_RST,
    output logic [15:0]                  settings,
    output logic                         go_idle_o,
    output logic [39:0]                  cmd_out,
    output logic                         req_out,
    output logic                         ack_out,
    input  logic                         req_in,
    input  logic                         ack_in,
    input  logic [39:0]                  cmd_in,
    input  logic [7:0]                   serial_status,
    input  logic                         card_detect,
    output logic                         card_present_o
);
    localparam int AW = $clog2(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, EXECUTE, CHECK} state_t;

    typedef struct packed {
        logic [13:0] set;
        logic [31:0] arg;
        logic        rd;
        logic        wr;
    } entry_t;

    state_t state, next_state;
    entry_t mem [QUEUE_DEPTH];
    entry_t head;
    logic [AW:0] wr_ptr, rd_ptr, level;
    logic full, empty, push_ok, overflow, pop, drained;
    logic req_meta, req_in_s, ack_meta, ack_in_s;
    logic [DEBOUNCE_W-1:0] db_cnt;
    logic present_q, removed;
    logic [TIMEOUT_W-1:0] wd;
    logic timeout;
    logic [2:0] retry_cnt;
    logic crc_valid_q, cice_q;
    logic chk_crc, chk_idx, chk_err;
    logic set_cte, set_ccrc, set_cie, set_cc, set_resp;
    logic go_idle, retry_inc, retry_clr;
    logic cc_q, drain_q;
    logic [6:0] head_rsize;
    logic unused_ok;

    assign head        = mem[rd_ptr[AW-1:0]];
    assign level       = wr_ptr - rd_ptr;
    assign empty       = (level == '0);
    assign full        = (level == (AW+1)'(QUEUE_DEPTH));
    assign push_ok     = cmd_push_i && (!full || pop || removed);
    assign overflow    = cmd_push_i && !push_ok;
    assign drained     = pop && (level == (AW+1)'(1)) && !push_ok;
    assign cmd_full_o  = full;
    assign cmd_level_o = level;

    assign card_present_o = &db_cnt;
    assign removed        = present_q && !card_present_o;
    assign timeout        = (state == EXECUTE) && (wd > TIMEOUT_REG);

    assign chk_crc = settings[7] && !crc_valid_q;
    assign chk_idx = cice_q && (cmd_in[37:32] != cmd_out[37:32]);
    assign chk_err = chk_crc || chk_idx;

    assign STATUS_REG     = {12'd0, retry_cnt, state != IDLE};
    assign NORMAL_INT_REG = {|ERR_INT_REG, 13'd0, drain_q, cc_q};

    assign unused_ok = ^{serial_status[7], serial_status[4:0], cmd_in[39:38],
                         head.set[5], head.set[2]};

    always_comb begin
        head_rsize = 7'd0;
        unique case (head.set[1:0])
            2'b00:   head_rsize = 7'd0;
            2'b01:   head_rsize = 7'd127;
            default: head_rsize = 7'd40;
        endcase
    end

    always_ff @(posedge CLK_PAD_IO) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= {cmd_set_i, arg_i, data_read_i, data_write_i};
    end

    always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_NI) begin
        if (!RST_PAD_NI)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        set_cte    = 1'b0;
        set_ccrc   = 1'b0;
        set_cie    = 1'b0;
        set_cc     = 1'b0;
        set_resp   = 1'b0;
        go_idle    = 1'b0;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && card_present_o)
                    next_state = SETUP;
            end
            SETUP: begin
                if (ack_in_s)
                    next_state = EXECUTE;
            end
            EXECUTE: begin
                if (req_in_s && serial_status[6]) begin
                    next_state = CHECK;
                end else if (timeout) begin
                    set_cte    = 1'b1;
                    go_idle    = 1'b1;
                    pop        = 1'b1;
                    retry_clr  = 1'b1;
                    next_state = IDLE;
                end
            end
            CHECK: begin
                if (chk_err && (int'(retry_cnt) < MAX_RETRY)) begin
                    retry_inc  = 1'b1;
                    next_state = SETUP;
                end else begin
                    set_cc     = 1'b1;
                    set_ccrc   = chk_crc;
                    set_cie    = chk_idx;
                    set_resp   = !chk_err && (settings[6:0] != 7'd0);
                    pop        = 1'b1;
                    retry_clr  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // Card removal overrides whatever the current state decided
        if (removed) begin
            next_state = IDLE;
            pop        = 1'b0;
            set_cte    = 1'b0;
            set_ccrc   = 1'b0;
            set_cie    = 1'b0;
            set_cc     = 1'b0;
            set_resp   = 1'b0;
            go_idle    = 1'b0;
            retry_inc  = 1'b0;
            retry_clr  = 1'b1;
        end
    end

    always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_NI) begin
        if (!RST_PAD_NI) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            req_meta    <= 1'b0;
            req_in_s    <= 1'b0;
            ack_meta    <= 1'b0;
            ack_in_s    <= 1'b0;
            db_cnt      <= '0;
            present_q   <= 1'b0;
            wd          <= '0;
            retry_cnt   <= '0;
            crc_valid_q <= 1'b0;
            cice_q      <= 1'b0;
            cmd_out     <= '0;
            settings    <= '0;
            RESP_1_REG  <= '0;
            ERR_INT_REG <= '0;
            cc_q        <= 1'b0;
            drain_q     <= 1'b0;
            go_idle_o   <= 1'b0;
            req_out     <= 1'b0;
            ack_out     <= 1'b0;
        end else begin
            req_meta  <= req_in;
            req_in_s  <= req_meta;
            ack_meta  <= ack_in;
            ack_in_s  <= ack_meta;
            present_q <= card_present_o;

            if (card_detect)
                db_cnt <= '0;
            else if (!card_present_o)
                db_cnt <= db_cnt + 1'b1;

            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (removed)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            if (state == SETUP) begin
                wd       <= '0;
                cmd_out  <= {2'b01, head.set[13:8], head.arg};
                settings <= {1'b0, head.set[7:6], head.rd, head.wr, 3'b111,
                             head.set[3], head_rsize};
                cice_q   <= head.set[4];
            end else if (state == EXECUTE && wd != '1) begin
                wd <= wd + 1'b1;
            end

            if (req_in_s && (state == IDLE || state == EXECUTE))
                crc_valid_q <= serial_status[5];

            if (retry_clr)
                retry_cnt <= '0;
            else if (retry_inc)
                retry_cnt <= retry_cnt + 1'b1;

            if (set_resp)
                RESP_1_REG <= cmd_in[31:0];

            if (ERR_INT_RST)
                ERR_INT_REG <= '0;
            else
                ERR_INT_REG <= ERR_INT_REG |
                    {removed, set_cie, overflow, set_ccrc, set_cte};

            if (NORMAL_INT_RST) begin
                cc_q    <= 1'b0;
                drain_q <= 1'b0;
            end else begin
                cc_q    <= cc_q | set_cc;
                drain_q <= drain_q | drained;
            end

            go_idle_o <= go_idle;
            req_out   <= (next_state == EXECUTE) ? ack_in_s : 1'b0;
            ack_out   <= req_in_s;
        end
    end
endmodule

// File: tb/tb_sd_cmd_master_q.sv
// tb_sd_cmd_master_q: randomized self-checking bench for sd_cmd_master_q
// with a queue-level reference model and a scripted serial engine.
module tb_sd_cmd_master_q;
    localparam int MR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_push_i = 1'b0;
    logic [13:0] cmd_set_i = '0;
    logic [31:0] arg_i = '0;
    logic        data_read_i = 1'b0;
    logic        data_write_i = 1'b0;
    logic        cmd_full_o;
    logic [2:0]  cmd_level_o;
    logic [15:0] TIMEOUT_REG = 16'd1000;
    logic [15:0] STATUS_REG;
    logic [31:0] RESP_1_REG;
    logic [4:0]  ERR_INT_REG;
    logic [15:0] NORMAL_INT_REG;
    logic        ERR_INT_RST = 1'b0;
    logic        NORMAL_INT_RST = 1'b0;
    logic [15:0] settings;
    logic        go_idle_o;
    logic [39:0] cmd_out;
    logic        req_out, ack_out;
    logic        req_in = 1'b0;
    logic        ack_in = 1'b0;
    logic [39:0] cmd_in = '0;
    logic [7:0]  serial_status = '0;
    logic        card_detect = 1'b1;
    logic        card_present_o;

    int checks = 0;
    int errors = 0;
    int issues = 0;
    int go_idles = 0;
    logic req_prev = 1'b0;
    logic [31:0] last_resp = '0;

    always #5 clk = ~clk;

    sd_cmd_master_q dut (
        .CLK_PAD_IO(clk), .RST_PAD_NI(rst_n),
        .cmd_push_i(cmd_push_i), .cmd_set_i(cmd_set_i), .arg_i(arg_i),
        .data_read_i(data_read_i), .data_write_i(data_write_i),
        .cmd_full_o(cmd_full_o), .cmd_level_o(cmd_level_o),
        .TIMEOUT_REG(TIMEOUT_REG), .STATUS_REG(STATUS_REG),
        .RESP_1_REG(RESP_1_REG), .ERR_INT_REG(ERR_INT_REG),
        .NORMAL_INT_REG(NORMAL_INT_REG), .ERR_INT_RST(ERR_INT_RST),
        .NORMAL_INT_RST(NORMAL_INT_RST), .settings(settings),
        .go_idle_o(go_idle_o), .cmd_out(cmd_out),
        .req_out(req_out), .ack_out(ack_out),
        .req_in(req_in), .ack_in(ack_in), .cmd_in(cmd_in),
        .serial_status(serial_status), .card_detect(card_detect),
        .card_present_o(card_present_o)
    );

    always @(negedge clk) begin
        if (req_out && !req_prev)
            issues++;
        req_prev = req_out;
        if (go_idle_o)
            go_idles++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [13:0] set, input logic [31:0] arg,
                        input logic rd, input logic wr);
        cmd_set_i = set;
        arg_i = arg;
        data_read_i = rd;
        data_write_i = wr;
        cmd_push_i = 1'b1;
        tick(1);
        cmd_push_i = 1'b0;
    endtask

    task automatic insert_card();
        int n;
        card_detect = 1'b0;
        n = 0;
        while (!card_present_o && n < 40) begin
            tick(1);
            n++;
        end
        if (!card_present_o)
            chk("wait_card_present", 64'(card_present_o), 64'd1);
    endtask

    task automatic clear_ints();
        ERR_INT_RST = 1'b1;
        NORMAL_INT_RST = 1'b1;
        tick(1);
        ERR_INT_RST = 1'b0;
        NORMAL_INT_RST = 1'b0;
        chk("err_cleared", 64'(ERR_INT_REG), 64'd0);
        chk("normal_cleared", 64'(NORMAL_INT_REG), 64'd0);
    endtask

    // One issue of the head command as seen by the serial engine
    task automatic run_issue(input logic crc, input logic [5:0] ridx,
                             input logic [31:0] rarg, input bit respond);
        int n;
        n = 0;
        while (!STATUS_REG[0] && n < 100) begin
            tick(1);
            n++;
        end
        if (!STATUS_REG[0])
            chk("wait_cicmd", 64'(STATUS_REG[0]), 64'd1);
        ack_in = 1'b1;
        n = 0;
        while (!req_out && n < 50) begin
            tick(1);
            n++;
        end
        if (!req_out)
            chk("wait_req_out", 64'(req_out), 64'd1);
        if (respond) begin
            tick(2);
            cmd_in = {2'b00, ridx, rarg};
            serial_status = {1'b0, 1'b1, crc, 5'b0};
            req_in = 1'b1;
            ack_in = 1'b0;
            n = 0;
            while (!ack_out && n < 20) begin
                tick(1);
                n++;
            end
            if (!ack_out)
                chk("wait_ack_out", 64'(ack_out), 64'd1);
            req_in = 1'b0;
            n = 0;
            while (ack_out && n < 20) begin
                tick(1);
                n++;
            end
            if (ack_out)
                chk("wait_ack_drop", 64'(ack_out), 64'd0);
        end
    endtask

    task automatic process_cmd(input logic [13:0] set, input logic [31:0] arg,
                               input logic rd, input logic wr,
                               input logic [3:0] crc_ok,
                               input logic [23:0] ridx,
                               input logic [127:0] rargs);
        int base, retries;
        logic err_c, err_i;
        logic [4:0] exp_err;
        logic [6:0] rsz;
        logic [15:0] exp_set;
        base = issues;
        retries = 0;
        exp_err = '0;
        rsz = (set[1:0] == 2'b00) ? 7'd0 : (set[1:0] == 2'b01) ? 7'd127 : 7'd40;
        exp_set = {1'b0, set[7:6], rd, wr, 3'b111, set[3], rsz};
        push(set, arg, rd, wr);
        for (int i = 0; i < 4; i++) begin
            run_issue(crc_ok[i], ridx[i*6 +: 6], rargs[i*32 +: 32], 1'b1);
            err_c = set[3] && !crc_ok[i];
            err_i = set[4] && (ridx[i*6 +: 6] != set[13:8]);
            if ((err_c || err_i) && retries < MR) begin
                retries++;
                chk("retry_count", 64'(STATUS_REG[3:1]), 64'(retries));
                chk("cicmd_retry", 64'(STATUS_REG[0]), 64'd1);
            end else begin
                exp_err = {1'b0, err_i, 1'b0, err_c, 1'b0};
                if (!(err_c || err_i) && rsz != 7'd0)
                    last_resp = rargs[i*32 +: 32];
                break;
            end
        end
        chk("issues", 64'(issues - base), 64'(retries + 1));
        chk("err_int", 64'(ERR_INT_REG), 64'(exp_err));
        chk("normal_int", 64'(NORMAL_INT_REG), 64'({|exp_err, 13'd0, 2'b11}));
        chk("resp_1", 64'(RESP_1_REG), 64'(last_resp));
        chk("cmd_out", 64'(cmd_out), 64'({2'b01, set[13:8], arg}));
        chk("settings", 64'(settings), 64'(exp_set));
        chk("status_idle", 64'(STATUS_REG), 64'd0);
        chk("level_empty", 64'(cmd_level_o), 64'd0);
        clear_ints();
    endtask

    initial begin
        int g0, n;
        logic [13:0] s;
        logic [23:0] ri;
        logic [3:0] ok;

        tick(3);
        chk("rst_status", 64'(STATUS_REG), 64'd0);
        chk("rst_err", 64'(ERR_INT_REG), 64'd0);
        chk("rst_normal", 64'(NORMAL_INT_REG), 64'd0);
        chk("rst_level", 64'(cmd_level_o), 64'd0);
        chk("rst_cmd_out", 64'(cmd_out), 64'd0);
        chk("rst_req_ack", 64'({req_out, ack_out, go_idle_o}), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Overflow with no card present
        for (int i = 0; i < 5; i++)
            push({6'(i + 1), 8'h01}, $urandom, 1'b0, 1'b0);
        chk("ovf_full", 64'(cmd_full_o), 64'd1);
        chk("ovf_level", 64'(cmd_level_o), 64'd4);
        chk("ovf_err", 64'(ERR_INT_REG), 64'h04);
        chk("ovf_ei", 64'(NORMAL_INT_REG), 64'h8000);
        ERR_INT_RST = 1'b1;
        push(14'h0101, 32'd0, 1'b0, 1'b0);
        ERR_INT_RST = 1'b0;
        chk("clr_beats_set", 64'(ERR_INT_REG), 64'd0);
        chk("ei_recomputed", 64'(NORMAL_INT_REG), 64'd0);

        // Reset in the middle of a command
        insert_card();
        run_issue(1'b0, 6'd0, 32'd0, 1'b0);
        rst_n = 1'b0;
        tick(2);
        chk("midrst_level", 64'(cmd_level_o), 64'd0);
        chk("midrst_status", 64'(STATUS_REG), 64'd0);
        chk("midrst_req", 64'(req_out), 64'd0);
        ack_in = 1'b0;
        rst_n = 1'b1;
        last_resp = '0;
        insert_card();

        // CMD17, RTS=01, good CRC
        process_cmd({6'd17, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01}, 32'h1000,
                    1'b1, 1'b0, 4'hF, {4{6'd17}}, {4{32'hCAFE_F00D}});
        chk("cmd17_cmd_out", 64'(cmd_out), 64'h51_0000_1000);
        chk("cmd17_rsize", 64'(settings[6:0]), 64'd127);

        // CRC bad three times, then once bad followed by good
        process_cmd({6'd24, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10}, 32'h55,
                    1'b0, 1'b1, 4'h0, {4{6'd24}}, {4{32'h1234_5678}});
        process_cmd({6'd8, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11}, 32'h1AA,
                    1'b0, 1'b0, 4'b1110, {4{6'd8}}, 128'h1_00000002_00000003_00000004);

        // Watchdog timeout
        TIMEOUT_REG = 16'd10;
        push(14'h0D01, 32'hABCD, 1'b0, 1'b0);
        g0 = go_idles;
        run_issue(1'b0, 6'd0, 32'd0, 1'b0);
        n = 0;
        while (go_idles == g0 && n < 100) begin
            tick(1);
            n++;
        end
        chk("to_latency_ok", 64'(n >= 10 && n <= 14), 64'd1);
        tick(3);
        chk("to_one_pulse", 64'(go_idles - g0), 64'd1);
        chk("to_err", 64'(ERR_INT_REG), 64'h01);
        chk("to_normal", 64'(NORMAL_INT_REG), 64'h8002);
        chk("to_popped", 64'(cmd_level_o), 64'd0);
        chk("to_status", 64'(STATUS_REG), 64'd0);
        ack_in = 1'b0;
        TIMEOUT_REG = 16'd1000;
        clear_ints();

        // Card pulled mid-EXECUTE with three queued
        for (int i = 0; i < 3; i++)
            push({6'(i + 2), 8'h01}, $urandom, 1'b0, 1'b0);
        run_issue(1'b0, 6'd0, 32'd0, 1'b0);
        card_detect = 1'b1;
        tick(3);
        chk("rm_level", 64'(cmd_level_o), 64'd0);
        chk("rm_err", 64'(ERR_INT_REG), 64'h10);
        chk("rm_status", 64'(STATUS_REG), 64'd0);
        chk("rm_req", 64'(req_out), 64'd0);
        ack_in = 1'b0;
        insert_card();
        clear_ints();

        // Randomized commands against the reference model
        for (int k = 0; k < 40; k++) begin
            s = 14'($urandom);
            ri = '0;
            for (int i = 0; i < 4; i++) begin
                ok[i] = ($urandom_range(0, 2) != 0);
                ri[i*6 +: 6] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : s[13:8];
            end
            process_cmd(s, $urandom, 1'($urandom), 1'($urandom), ok, ri,
                        {$urandom, $urandom, $urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
